// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift mode encoding shared by the shifter pipeline and its stages
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROL = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one conditional shift-by-STAGE_SHIFT step with carry update
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STAGE_SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  input  logic             carry_i,
  input  logic             shift_en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o
);

  shift_op_t op;
  assign op = shift_op_t'(op_i);

  // Rotates leave the carry alone; the top derives it from the final result.
  always_comb begin
    data_o  = data_i;
    carry_o = carry_i;
    if (shift_en_i) begin
      case (op)
        SHIFT_SLL: begin
          data_o  = data_i << STAGE_SHIFT;
          carry_o = data_i[WIDTH-STAGE_SHIFT];
        end
        SHIFT_SRL: begin
          data_o  = data_i >> STAGE_SHIFT;
          carry_o = data_i[STAGE_SHIFT-1];
        end
        SHIFT_SRA: begin
          data_o  = $signed(data_i) >>> STAGE_SHIFT;
          carry_o = data_i[STAGE_SHIFT-1];
        end
        SHIFT_ROL: begin
          data_o  = (data_i << STAGE_SHIFT) | (data_i >> (WIDTH-STAGE_SHIFT));
        end
        default: begin
          data_o  = data_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter, one registered stage per shamt bit
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  localparam int LAST = LOG2W - 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [LOG2W-1:0] shamt;
    logic [1:0]       op;
    logic             carry;
  } stage_t;

  stage_t           stage_in [LOG2W];
  stage_t           stage_d  [LOG2W];
  stage_t           stage_q  [LOG2W];
  logic [LOG2W-1:0] valid_d;
  logic [LOG2W-1:0] valid_q;
  logic             stall;

  // Global stall: a blocked output freezes every stage, bubbles included.
  assign stall    = valid_q[LAST] && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    logic [WIDTH-1:0] data_nx;
    logic             carry_nx;

    if (k == 0) begin : g_head
      assign stage_in[k] = '{data: in_data, shamt: in_shamt, op: in_op, carry: 1'b0};
      assign valid_d[k]  = in_valid;
    end else begin : g_body
      assign stage_in[k] = stage_q[k-1];
      assign valid_d[k]  = valid_q[k-1];
    end

    shift_stage #(
      .WIDTH       (WIDTH),
      .STAGE_SHIFT (1 << k)
    ) u_stage (
      .data_i     (stage_in[k].data),
      .op_i       (stage_in[k].op),
      .carry_i    (stage_in[k].carry),
      .shift_en_i (stage_in[k].shamt[k]),
      .data_o     (data_nx),
      .carry_o    (carry_nx)
    );

    assign stage_d[k] = '{data: data_nx, shamt: stage_in[k].shamt,
                          op: stage_in[k].op, carry: carry_nx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LOG2W; k++) begin
        stage_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (!stall) begin
      for (int k = 0; k < LOG2W; k++) begin
        stage_q[k] <= stage_d[k];
      end
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = stage_q[LAST].data;
  // A rotate's carry is the bit that wrapped into the LSB, or 0 when nothing moved.
  assign out_carry = (shift_op_t'(stage_q[LAST].op) == SHIFT_ROL)
                   ? ((|stage_q[LAST].shamt) & stage_q[LAST].data[0])
                   : stage_q[LAST].carry;

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed, stall, reset and randomised checks of shift_pipe
module tb_shift_pipe;
  import shift_pkg::*;

  localparam int W  = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [LW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_carry;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  typedef struct {
    logic [1:0]   op;
    int           shamt;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
    logic         exp_carry;
  } vec_t;

  vec_t          vecs[$];
  int            tests = 0;
  int            fails = 0;
  logic          mon_en = 1'b0;
  logic [W:0]    sb[$];
  int            out_cnt = 0;
  int            cyc = 0;
  int            out_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Whole-word reference: {carry, result} straight from the mode rules.
  function automatic logic [W:0] ref_shift(input logic [1:0] op, input int s, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic         c;
    c = 1'b0;
    case (op)
      2'd0: begin r = d << s; if (s != 0) c = d[W-s]; end
      2'd1: begin r = d >> s; if (s != 0) c = d[s-1]; end
      2'd2: begin
        r = d >> s;
        if (d[W-1]) r = r | ~(16'hFFFF >> s);
        if (s != 0) c = d[s-1];
      end
      default: begin r = (d << s) | (d >> (W-s)); if (s != 0) c = r[0]; end
    endcase
    return {c, r};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready)
        sb.push_back(ref_shift(in_op, int'(in_shamt), in_data));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got %0h, expected no result", {out_carry, out_data});
        end else begin
          check("sb_result", 32'({out_carry, out_data}), 32'(sb.pop_front()));
        end
        out_cnt++;
        out_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive_op(input logic [1:0] op, input logic [LW-1:0] sh, input logic [W-1:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_shamt = sh;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) timeout_fail("accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 0;
    out_ready = 1'b1;
    drive_op(v.op, 4'(v.shamt), v.data);
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("vec_latency", 32'(lat), 32'(LW));
    check("vec_data", 32'(out_data), 32'(v.exp_data));
    check("vec_carry", 32'(out_carry), 32'(v.exp_carry));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W:0] held;
    int         w;
    int         stale;
    logic       done;

    vecs.push_back('{SHIFT_SLL,  4, 16'h0001, 16'h0010, 1'b0});
    vecs.push_back('{SHIFT_SRL,  1, 16'h8001, 16'h4000, 1'b1});
    vecs.push_back('{SHIFT_SRA, 15, 16'h8000, 16'hFFFF, 1'b0});
    vecs.push_back('{SHIFT_SLL,  2, 16'hC000, 16'h0000, 1'b1});
    vecs.push_back('{SHIFT_ROL,  1, 16'h8001, 16'h0003, 1'b1});
    vecs.push_back('{SHIFT_SLL,  0, 16'hA5A5, 16'hA5A5, 1'b0});
    vecs.push_back('{SHIFT_SRL,  0, 16'hA5A5, 16'hA5A5, 1'b0});
    vecs.push_back('{SHIFT_SRA,  0, 16'hA5A5, 16'hA5A5, 1'b0});
    vecs.push_back('{SHIFT_ROL,  0, 16'hA5A5, 16'hA5A5, 1'b0});
    vecs.push_back('{SHIFT_SRA,  4, 16'h8421, 16'hF842, 1'b0});
    vecs.push_back('{SHIFT_ROL,  4, 16'h1234, 16'h2341, 1'b1});
    vecs.push_back('{SHIFT_SRL, 15, 16'hFFFF, 16'h0001, 1'b1});
    vecs.push_back('{SHIFT_SLL, 15, 16'h0003, 16'h8000, 1'b1});

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_shamt = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_carry", 32'(out_carry), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back stream, then a three-cycle output stall.
    sb.delete(); out_cyc.delete(); out_cnt = 0; mon_en = 1'b1; out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++)
          drive_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
      begin
        w = 0;
        while (out_cnt < 8 && w < 200) begin
          @(negedge clk);
          w++;
        end
        if (out_cnt < 8) timeout_fail("stream_first8");
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (c == 0) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            held = {out_carry, out_data};
          end else begin
            check("stall_hold", 32'({out_carry, out_data}), 32'(held));
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    w = 0;
    while (out_cnt < 12 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("stream_count", 32'(out_cnt), 32'd12);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 1; i < 8 && i < out_cyc.size(); i++)
      check("stream_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
    mon_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three ops in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_op(SHIFT_SLL, 4'(i + 1), 16'h00FF);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_valid", 32'(stale), 32'd0);
    check("reset_recover_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    run_vec(vecs[1]);

    // Randomised traffic with random backpressure against the reference model.
    sb.delete(); out_cyc.delete(); out_cnt = 0; mon_en = 1'b1; done = 1'b0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          drive_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    w = 0;
    while (out_cnt < 10000 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("rand_count", 32'(out_cnt), 32'd10000);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
